// File: rtl/context_memory_banked.sv
// Banked CGRA context memory: one SRAM-style bank per row with independent
// registered read ports, a shared (broadcast-capable) write port, a
// line-by-line clear sequencer and a retention mode that freezes all ports.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   set_retentive_i       hold contents, freeze all ports
//   clear_i               one-cycle pulse, zero every bank
//   busy_o                high while clearing or retentive
//   wr_valid_i/ready_o    write handshake
//   wr_row_mask_i         banks written by this beat
//   wr_addr_i, wr_data_i  write line and word
//   rd_req_i, rd_addr_i   per-bank read request and address (bank r at r*ADDR_W)
//   rd_data_o, rd_valid_o per-bank registered read word and valid
module context_memory_banked #(
    parameter int N_ROW          = 4,
    parameter int N_LINES        = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_W        = $clog2(N_LINES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          set_retentive_i,
    input  logic                          clear_i,
    output logic                          busy_o,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [N_ROW-1:0]              wr_row_mask_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic [N_ROW-1:0]              rd_req_i,
    input  logic [N_ROW*ADDR_W-1:0]       rd_addr_i,
    output logic [N_ROW*DATA_WIDTH-1:0]   rd_data_o,
    output logic [N_ROW-1:0]              rd_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RET
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               clr_last;
    logic               clearing;
    logic               wr_fire;
    logic               rd_ok;

    assign clr_last = (clr_cnt == ADDR_W'(N_LINES - 1));
    assign clearing = (state == S_CLEAR) && !rst_i;
    assign rd_ok    = (state == S_IDLE) && !rst_i;

    // Ready/busy follow reset directly so nothing is accepted while
    // reset is held, and a pending auto-clear already shows as busy.
    assign wr_ready_o = (state == S_IDLE) && !rst_i;
    assign busy_o     = rst_i ? CLEAR_ON_RESET : (state != S_IDLE);
    assign wr_fire    = wr_valid_i && wr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Retention outranks clear; once clearing, requests are ignored.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (set_retentive_i) begin
                    state_nxt = S_RET;
                end else if (clear_i) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RET: begin
                if (!set_retentive_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    for (genvar r = 0; r < N_ROW; r++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [N_LINES];
        logic [ADDR_W-1:0]     raddr;

        assign raddr = rd_addr_i[r*ADDR_W +: ADDR_W];

        // Array has no reset so it maps onto plain SRAM macros.
        always_ff @(posedge clk_i) begin
            if (clearing) begin
                mem[clr_cnt] <= '0;
            end else if (wr_fire && wr_row_mask_i[r]) begin
                mem[wr_addr_i] <= wr_data_i;
            end
        end

        // Non-blocking update gives read-before-write on a same-line hit.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_valid_o[r]                        <= 1'b0;
                rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] <= '0;
            end else begin
                rd_valid_o[r] <= rd_req_i[r] && rd_ok;
                if (rd_req_i[r] && rd_ok) begin
                    rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_context_memory_banked.sv
// Directed bench for context_memory_banked at default parameters.
// Expected values are hand-computed constants per step.
module tb_context_memory_banked;

    logic         clk = 1'b0;
    logic         rst;
    logic         set_ret;
    logic         clear;
    logic         busy;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_mask;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [3:0]   rd_req;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_valid;

    int vectors = 0;
    int errs    = 0;
    int n;

    always #5 clk = ~clk;

    context_memory_banked dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .set_retentive_i(set_ret),
        .clear_i        (clear),
        .busy_o         (busy),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_row_mask_i  (wr_mask),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .rd_req_i       (rd_req),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] addr4(input int a3, input int a2,
                                          input int a1, input int a0);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    initial begin
        rst = 1'b1; set_ret = 1'b0; clear = 1'b0;
        wr_valid = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
        step(); step();
        check("rst_busy", 128'(busy), 128'(1'b1));
        check("rst_ready", 128'(wr_ready), 128'(1'b0));
        check("rst_valid", 128'(rd_valid), 128'(4'h0));
        check("rst_data", rd_data, 128'h0);

        // auto-clear after reset release
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; step(); end
        check("init_clear_len", 128'(n), 128'(32));
        check("init_ready", 128'(wr_ready), 128'(1'b1));
        check("init_busy", 128'(busy), 128'(1'b0));

        rd_req = 4'hF; rd_addr = addr4(5, 5, 5, 5);
        step();
        check("line5_valid", 128'(rd_valid), 128'(4'hF));
        check("line5_data", rd_data, 128'h0);
        rd_req = 4'h0;
        step();
        check("noreq_valid", 128'(rd_valid), 128'(4'h0));

        // broadcast write, plus last line of bank 3
        wr_valid = 1'b1; wr_mask = 4'b1010; wr_addr = 5'd3;
        wr_data = 32'hDEADBEEF;
        step();
        wr_mask = 4'b1000; wr_addr = 5'd31; wr_data = 32'hCAFEF00D;
        step();
        wr_valid = 1'b0;
        rd_req = 4'hF; rd_addr = addr4(3, 3, 3, 3);
        step();
        check("bcast_valid", 128'(rd_valid), 128'(4'hF));
        check("bcast_data", rd_data,
              128'hDEADBEEF_00000000_DEADBEEF_00000000);

        // read-before-write on bank 2 line 7
        rd_req = 4'h0;
        wr_valid = 1'b1; wr_mask = 4'b0100; wr_addr = 5'd7;
        wr_data = 32'h11111111;
        step();
        wr_data = 32'h22222222;
        rd_req = 4'b0100; rd_addr = addr4(0, 7, 0, 0);
        step();
        check("rbw_valid", 128'(rd_valid), 128'(4'b0100));
        check("rbw_old", rd_data,
              128'hDEADBEEF_11111111_DEADBEEF_00000000);
        wr_valid = 1'b0;
        step();
        check("rbw_new", rd_data,
              128'hDEADBEEF_22222222_DEADBEEF_00000000);

        // independent addresses per bank, mask 0 is a no-op
        rd_req = 4'h0;
        wr_valid = 1'b1; wr_mask = 4'b0001; wr_addr = 5'd10;
        wr_data = 32'hA0A0A0A0;
        step();
        wr_mask = 4'b0010; wr_addr = 5'd20; wr_data = 32'hB1B1B1B1;
        step();
        wr_mask = 4'b0000; wr_addr = 5'd10; wr_data = 32'hFFFFFFFF;
        step();
        wr_valid = 1'b0;
        rd_req = 4'hF; rd_addr = addr4(31, 7, 20, 10);
        step();
        check("indep_data", rd_data,
              128'hCAFEF00D_22222222_B1B1B1B1_A0A0A0A0);
        rd_req = 4'h0;
        step();
        check("hold_valid", 128'(rd_valid), 128'(4'h0));
        check("hold_data", rd_data,
              128'hCAFEF00D_22222222_B1B1B1B1_A0A0A0A0);

        // retention for 10 cycles with traffic attempted
        set_ret = 1'b1;
        step();
        check("ret_busy", 128'(busy), 128'(1'b1));
        check("ret_ready", 128'(wr_ready), 128'(1'b0));
        wr_valid = 1'b1; wr_mask = 4'hF; wr_addr = 5'd3;
        wr_data = 32'h55555555;
        rd_req = 4'hF; rd_addr = addr4(3, 3, 3, 3);
        for (int i = 0; i < 9; i++) begin
            step();
            check("ret_ready_loop", 128'(wr_ready), 128'(1'b0));
            check("ret_valid_loop", 128'(rd_valid), 128'(4'h0));
            check("ret_data_loop", rd_data,
                  128'hCAFEF00D_22222222_B1B1B1B1_A0A0A0A0);
        end
        set_ret = 1'b0; wr_valid = 1'b0; rd_req = 4'h0;
        check("ret_exit_wait", 128'(wr_ready), 128'(1'b0));
        step();
        check("ret_exit_ready", 128'(wr_ready), 128'(1'b1));
        check("ret_exit_busy", 128'(busy), 128'(1'b0));
        rd_req = 4'hF; rd_addr = addr4(3, 3, 3, 3);
        step();
        check("ret_kept", rd_data,
              128'hDEADBEEF_00000000_DEADBEEF_00000000);

        // retention beats clear; write on the transition edge lands
        rd_req = 4'h0;
        set_ret = 1'b1; clear = 1'b1;
        wr_valid = 1'b1; wr_mask = 4'b0001; wr_addr = 5'd12;
        wr_data = 32'h12345678;
        check("trans_ready", 128'(wr_ready), 128'(1'b1));
        step();
        clear = 1'b0; wr_valid = 1'b0;
        check("both_busy", 128'(busy), 128'(1'b1));
        set_ret = 1'b0;
        step();
        check("both_noclear", 128'(busy), 128'(1'b0));
        rd_req = 4'hF; rd_addr = addr4(31, 3, 3, 12);
        step();
        check("both_kept", rd_data,
              128'hCAFEF00D_00000000_DEADBEEF_12345678);

        // clear interrupted by reset at clear cycle 10
        rd_req = 4'h0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", 128'(busy), 128'(1'b1));
        rd_req = 4'hF;
        for (int i = 0; i < 10; i++) step();
        check("clr_rd_blocked", 128'(rd_valid), 128'(4'h0));
        rst = 1'b1; rd_req = 4'h0;
        step();
        check("rst2_busy", 128'(busy), 128'(1'b1));
        check("rst2_ready", 128'(wr_ready), 128'(1'b0));
        check("rst2_data", rd_data, 128'h0);
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            clear   = (n < 4);
            set_ret = (n < 4);
            n++;
            step();
        end
        clear = 1'b0; set_ret = 1'b0;
        check("reclear_len", 128'(n), 128'(32));
        rd_req = 4'hF; rd_addr = addr4(31, 7, 3, 12);
        step();
        check("reclear_valid", 128'(rd_valid), 128'(4'hF));
        check("reclear_data", rd_data, 128'h0);
        rd_addr = addr4(3, 3, 20, 0);
        step();
        check("reclear_data2", rd_data, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
